// File: rtl/oam_dma.sv
// oam_dma: sprite DMA copying one CPU page into OAM port B.
// Define OAM_DMA_ALIGN_EN to insert the get/put alignment cycle after HALT.
module oam_dma #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter int          XFER_LEN  = 256
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    input  logic [7:0]  oam_base,
    output logic        cpu_halt,
    output logic        busy,
    output logic [15:0] ram_addr,
    output logic        ram_rd,
    input  logic [7:0]  ram_q,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_din,
    output logic        oam_wren,
    output logic        done
);

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {
        IDLE, HALT, ALIGN, READ, WRITE, FINISH
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, HALT, READ, WRITE, FINISH
    } state_t;
`endif

    // idx is one bit wider than a byte so the terminal compare never aliases
    localparam logic [8:0] LAST = 9'(XFER_LEN - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] page;
    logic [7:0] base;
    logic [8:0] idx;
    logic       trig;

    assign trig = cpu_wr && (cpu_addr == TRIG_ADDR);

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state <= IDLE;
            page  <= 8'h00;
            base  <= 8'h00;
            idx   <= 9'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && trig) begin
                page <= cpu_dout;
                base <= oam_base;
                idx  <= 9'd0;
            end else if (state == WRITE) begin
                idx <= idx + 9'd1;
            end
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    // get (0) / put (1) cycle marker
    logic parity;

    always_ff @(posedge clk) begin
        if (!res_n) parity <= 1'b0;
        else        parity <= ~parity;
    end
`endif

    always_comb begin
        state_nx = state;
        cpu_halt = 1'b1;
        busy     = 1'b1;
        ram_addr = 16'h0000;
        ram_rd   = 1'b0;
        oam_addr = 8'h00;
        oam_din  = 8'h00;
        oam_wren = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                cpu_halt = 1'b0;
                busy     = 1'b0;
                if (trig) state_nx = HALT;
            end
`ifdef OAM_DMA_ALIGN_EN
            HALT:  state_nx = parity ? ALIGN : READ;
            ALIGN: state_nx = READ;
`else
            HALT:  state_nx = READ;
`endif
            READ: begin
                ram_addr = {page, idx[7:0]};
                ram_rd   = 1'b1;
                state_nx = WRITE;
            end
            WRITE: begin
                oam_addr = base + idx[7:0];
                oam_din  = ram_q;
                oam_wren = 1'b1;
                state_nx = (idx == LAST) ? FINISH : READ;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: queue-based scoreboard bench for the OAM sprite DMA.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_wr = 1'b0;
    logic [7:0]  oam_base = 8'h00;
    logic        cpu_halt;
    logic        busy;
    logic [15:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_q = 8'h00;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_din;
    logic        oam_wren;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam [0:255];
    logic        par = 1'b0;
    logic        aborted = 1'b0;

    logic [15:0] wr_q [$];
    logic [15:0] rd_q [$];
    int          hl_q [$];

    oam_dma dut (
        .clk      (clk),
        .res_n    (res_n),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_wr   (cpu_wr),
        .oam_base (oam_base),
        .cpu_halt (cpu_halt),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_rd   (ram_rd),
        .ram_q    (ram_q),
        .oam_addr (oam_addr),
        .oam_din  (oam_din),
        .oam_wren (oam_wren),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr];

    // get/put phase as seen by the bench
    always @(posedge clk) par <= res_n ? ~par : 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: pops expectations whenever the DUT presents a read or a write
    int hcnt = 0;
    int dcnt = 0;
    always @(negedge clk) begin
        logic [15:0] e;
        int          h;
        if (ram_rd) begin
            if (rd_q.size() == 0) check("unexpected_read", 32'(ram_addr), -1);
            else begin
                e = rd_q.pop_front();
                check("ram_addr", 32'(ram_addr), 32'(e));
            end
        end
        if (oam_wren) begin
            oam[oam_addr] = oam_din;
            if (wr_q.size() == 0) check("unexpected_write", 32'(oam_addr), -1);
            else begin
                e = wr_q.pop_front();
                check("oam_addr", 32'(oam_addr), 32'(e[15:8]));
                check("oam_din", 32'(oam_din), 32'(e[7:0]));
            end
        end
        if (cpu_halt) begin
            hcnt++;
            if (done) dcnt++;
        end else if (hcnt > 0) begin
            if (aborted) aborted = 1'b0;
            else begin
                h = (hl_q.size() > 0) ? hl_q.pop_front() : -1;
                check("halt_len", hcnt, h);
                check("done_pulses", dcnt, 1);
            end
            hcnt = 0;
            dcnt = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    // want_par: -1 any, else required parity of the trigger cycle
    task automatic trigger(input logic [7:0] pg, input logic [7:0] bs,
                           input int want_par);
        int hl;
        wait_idle();
        if (want_par >= 0 && par != want_par[0]) begin
            @(posedge clk); #1;
        end
        hl = 514;
`ifdef OAM_DMA_ALIGN_EN
        if (par == 1'b0) hl = 515;
`endif
        hl_q.push_back(hl);
        for (int i = 0; i < 256; i++) begin
            rd_q.push_back({pg, 8'(i)});
            wr_q.push_back({8'(bs + 8'(i)), mem[{pg, 8'(i)}]});
        end
        cpu_addr = 16'h4014;
        cpu_dout = pg;
        oam_base = bs;
        cpu_wr   = 1'b1;
        @(posedge clk); #1;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
        oam_base = ~bs;
        check("busy_rise", 32'(busy), 1);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_dout = d;
        cpu_wr   = 1'b1;
        @(posedge clk); #1;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++)
            mem[a] = 8'(a) ^ 8'h5A ^ (8'(a >> 8) - 8'h02);
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {busy, cpu_halt, done, oam_wren, ram_rd}, 0);
        res_n = 1'b1;
        @(posedge clk); #1;

        // page $02, base $00, HALT on even parity
        trigger(8'h02, 8'h00, 1);
        wait_idle();
        check("oam_10", 32'(oam[8'h10]), 32'h4A);
        check("oam_ff", 32'(oam[8'hFF]), 32'hA5);

        // HALT on odd parity
        trigger(8'h02, 8'h00, 0);
        wait_idle();

        // base wrap
        trigger(8'h07, 8'hF0, -1);
        wait_idle();
        check("oam_f0", 32'(oam[8'hF0]), 32'h5F);
        check("oam_ff_w", 32'(oam[8'hFF]), 32'h50);
        check("oam_00_w", 32'(oam[8'h00]), 32'h4F);
        check("oam_ef_w", 32'(oam[8'hEF]), 32'hA0);

        // retrigger while busy is ignored
        trigger(8'h02, 8'h00, -1);
        repeat (100) @(posedge clk);
        #1;
        cpu_write(16'h4014, 8'h03);
        wait_idle();

        // reset mid-transfer
        trigger(8'h05, 8'h11, -1);
        repeat (200) @(posedge clk);
        #1;
        res_n = 1'b0;
        @(posedge clk); #1;
        aborted = 1'b1;
        wr_q.delete();
        rd_q.delete();
        hl_q.delete();
        check("abort_outs", {busy, cpu_halt, oam_wren, done}, 0);
        res_n = 1'b1;
        trigger(8'h02, 8'h00, -1);
        wait_idle();

        // top page, no carry
        trigger(8'hFF, 8'h00, -1);
        wait_idle();

        // neighbouring addresses never trigger
        cpu_write(16'h4013, 8'h02);
        repeat (2) @(posedge clk);
        #1;
        check("no_trig_4013", 32'(busy), 0);
        cpu_write(16'h4015, 8'h02);
        repeat (2) @(posedge clk);
        #1;
        check("no_trig_4015", 32'(busy), 0);

        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        check("hl_q_empty", hl_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
